// File: rtl/fifo_rd_stream_if.sv
// Bundle of the FIFO read port and the downstream valid/ready stream around fifo_rd_stream.
// master = the adapter; slave = the FIFO plus downstream environment.
interface fifo_rd_stream_if #(
  parameter int RW         = 64,
  parameter int OBUF_DEPTH = 3
);
  localparam int CW = $clog2(OBUF_DEPTH + 1);

  logic          fifo_rden;
  logic [RW-1:0] fifo_dout;
  logic          fifo_empty;
  logic          m_valid;
  logic          m_ready;
  logic [RW-1:0] m_data;
  logic [CW-1:0] m_count;

  modport master (
    output fifo_rden, m_valid, m_data, m_count,
    input  fifo_dout, fifo_empty, m_ready
  );

  modport slave (
    input  fifo_rden, m_valid, m_data, m_count,
    output fifo_dout, fifo_empty, m_ready
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Drains a registered-read FIFO into a valid/ready stream through a small circular buffer.
// Pops are issued on credit (cnt + pend) so the buffer can never overflow.
module fifo_rd_stream #(
  parameter int RW         = 64,
  parameter int OBUF_DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  fifo_rd_stream_if.master bus
);
  localparam int CW = $clog2(OBUF_DEPTH + 1);
  localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;

  logic [RW-1:0] obuf_q [OBUF_DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic [RW-1:0] data_q, data_d;
  logic [CW:0]   credit;
  logic          rden;
  logic          capture;
  logic          transfer;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OBUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pop decision uses registered state only, so m_ready never reaches fifo_rden.
  assign credit   = {1'b0, cnt_q} + {{CW{1'b0}}, pend_q};
  assign rden     = rst_n & ~flush_i & ~bus.fifo_empty & (credit < (CW+1)'(OBUF_DEPTH));
  assign capture  = pend_q;
  assign transfer = (cnt_q != '0) & bus.m_ready;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    pend_d = 1'b0;
    data_d = data_q;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      pend_d = rden;
      if (capture)  tail_d = ptr_inc(tail_q);
      if (transfer) head_d = ptr_inc(head_q);
      cnt_d = cnt_q + CW'(capture) - CW'(transfer);
      // data_q mirrors the post-edge head entry; the slot being written bypasses the array.
      if (cnt_d != '0) begin
        if (capture && (head_d == tail_q)) data_d = bus.fifo_dout;
        else                               data_d = obuf_q[head_d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      data_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      data_q <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capture && !flush_i) obuf_q[tail_q] <= bus.fifo_dout;
  end

  assign bus.fifo_rden = rden;
  assign bus.m_valid   = (cnt_q != '0);
  assign bus.m_data    = data_q;
  assign bus.m_count   = cnt_q;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural registered-read FIFO in front of it.
module tb_fifo_rd_stream;
  localparam int RW = 64;
  localparam int D  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  fifo_rd_stream_if #(.RW(RW), .OBUF_DEPTH(D)) bus ();

  fifo_rd_stream #(.RW(RW), .OBUF_DEPTH(D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .bus     (bus)
  );

  // Behavioural FIFO: pushes come from the tasks, pops from the DUT, dout one cycle after rden.
  logic [RW-1:0] mem [64];
  int unsigned   wr_ptr = 0;
  int unsigned   rd_ptr = 0;
  assign bus.fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (bus.fifo_rden && (wr_ptr != rd_ptr)) begin
      bus.fifo_dout <= mem[rd_ptr % 64];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [RW-1:0] beats [$];
  int            rden_cnt;
  logic [31:0]   rden_pat;
  logic [31:0]   valid_pat;
  int            cyc;

  task automatic push(input logic [RW-1:0] w);
    mem[wr_ptr % 64] = w;
    wr_ptr++;
  endtask

  task automatic clear_mon();
    beats.delete();
    rden_cnt  = 0;
    rden_pat  = '0;
    valid_pat = '0;
    cyc       = 0;
  endtask

  // Called at a negedge with inputs set; records this cycle, returns at the next negedge.
  task automatic tick();
    #1;
    if (bus.fifo_rden) begin
      rden_cnt++;
      if (cyc < 32) rden_pat[cyc] = 1'b1;
    end
    if (bus.m_valid && cyc < 32) valid_pat[cyc] = 1'b1;
    if (bus.m_valid && bus.m_ready && !flush && rst_n) begin
      beats.push_back(bus.m_data);
      $display("beat cyc=%0d data=%h count=%0d", cyc, bus.m_data, bus.m_count);
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.m_ready = 1'b0;
    rst_n = 1'b0;
    push(64'h55);
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (bus.fifo_rden !== 1'b0) begin n_bad++; $display("FAIL reset_rden: got %b want 0", bus.fifo_rden); end
    n_cmp++; if (bus.m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.m_valid); end
    n_cmp++; if (bus.m_data !== 64'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", bus.m_data); end
    n_cmp++; if (bus.m_count !== 2'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", bus.m_count); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    rst_n = 1'b1;
    $display("reset done");
  endtask

  task automatic test_stream();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(64'hA0 + 64'(i));
    clear_mon();
    repeat (10) tick();
    n_cmp++; if (rden_pat !== 32'h0000_000F) begin n_bad++; $display("FAIL stream_rden: got %h want 0000000f", rden_pat); end
    n_cmp++; if (valid_pat !== 32'h0000_003C) begin n_bad++; $display("FAIL stream_valid: got %h want 0000003c", valid_pat); end
    n_cmp++; if (beats.size() !== 4) begin n_bad++; $display("FAIL stream_beats: got %0d want 4", beats.size()); end
    for (int i = 0; i < beats.size() && i < 4; i++) begin
      n_cmp++; if (beats[i] !== 64'hA0 + 64'(i)) begin n_bad++; $display("FAIL stream_data%0d: got %h want %h", i, beats[i], 64'hA0 + 64'(i)); end
    end
  endtask

  task automatic test_backpressure();
    bus.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(64'hA0 + 64'(i));
    clear_mon();
    repeat (8) tick();
    n_cmp++; if (rden_cnt !== 3) begin n_bad++; $display("FAIL bp_rden_cnt: got %0d want 3", rden_cnt); end
    n_cmp++; if (bus.m_count !== 2'd3) begin n_bad++; $display("FAIL bp_count: got %0d want 3", bus.m_count); end
    n_cmp++; if (bus.m_data !== 64'hA0) begin n_bad++; $display("FAIL bp_head: got %h want a0", bus.m_data); end
    n_cmp++; if (valid_pat !== 32'h0000_00FC) begin n_bad++; $display("FAIL bp_valid: got %h want 000000fc", valid_pat); end
    bus.m_ready = 1'b1;
    clear_mon();
    repeat (6) tick();
    n_cmp++; if (beats.size() !== 5) begin n_bad++; $display("FAIL bp_beats: got %0d want 5", beats.size()); end
    n_cmp++; if (rden_cnt !== 2) begin n_bad++; $display("FAIL bp_rden_rest: got %0d want 2", rden_cnt); end
    for (int i = 0; i < beats.size() && i < 5; i++) begin
      n_cmp++; if (beats[i] !== 64'hA0 + 64'(i)) begin n_bad++; $display("FAIL bp_data%0d: got %h want %h", i, beats[i], 64'hA0 + 64'(i)); end
    end
  endtask

  task automatic test_flush();
    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(64'hC0 + 64'(i));
    clear_mon();
    repeat (3) tick();
    n_cmp++; if (bus.m_count !== 2'd2) begin n_bad++; $display("FAIL flush_pre_count: got %0d want 2", bus.m_count); end
    n_cmp++; if (bus.m_valid !== 1'b1) begin n_bad++; $display("FAIL flush_pre_valid: got %b want 1", bus.m_valid); end
    flush = 1'b1;
    bus.m_ready = 1'b1;
    #1;
    n_cmp++; if (bus.fifo_rden !== 1'b0) begin n_bad++; $display("FAIL flush_rden: got %b want 0", bus.fifo_rden); end
    tick();
    flush = 1'b0;
    #1;
    n_cmp++; if (bus.m_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b want 0", bus.m_valid); end
    n_cmp++; if (bus.m_count !== 2'd0) begin n_bad++; $display("FAIL flush_count: got %0d want 0", bus.m_count); end
    @(negedge clk);
    push(64'hD0);
    push(64'hD1);
    clear_mon();
    repeat (6) tick();
    n_cmp++; if (beats.size() !== 2) begin n_bad++; $display("FAIL flush_beats: got %0d want 2", beats.size()); end
    for (int i = 0; i < beats.size() && i < 2; i++) begin
      n_cmp++; if (beats[i] !== 64'hD0 + 64'(i)) begin n_bad++; $display("FAIL flush_data%0d: got %h want %h", i, beats[i], 64'hD0 + 64'(i)); end
    end
  endtask

  task automatic test_back_to_back();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 10; i++) push(64'hE0 + 64'(i));
    clear_mon();
    for (int i = 0; i < 14; i++) begin
      if (i >= 2 && i <= 11) begin
        n_cmp++; if (bus.m_count !== 2'd1) begin n_bad++; $display("FAIL b2b_count_c%0d: got %0d want 1", i, bus.m_count); end
      end
      tick();
    end
    n_cmp++; if (beats.size() !== 10) begin n_bad++; $display("FAIL b2b_beats: got %0d want 10", beats.size()); end
    for (int i = 0; i < beats.size() && i < 10; i++) begin
      n_cmp++; if (beats[i] !== 64'hE0 + 64'(i)) begin n_bad++; $display("FAIL b2b_data%0d: got %h want %h", i, beats[i], 64'hE0 + 64'(i)); end
    end
    for (int i = 0; i < 10; i++) push(64'hF0 + 64'(i));
    clear_mon();
    for (int i = 0; i < 30; i++) begin
      bus.m_ready = (i % 2 == 0);
      tick();
    end
    n_cmp++; if (beats.size() !== 10) begin n_bad++; $display("FAIL wrap_beats: got %0d want 10", beats.size()); end
    for (int i = 0; i < beats.size() && i < 10; i++) begin
      n_cmp++; if (beats[i] !== 64'hF0 + 64'(i)) begin n_bad++; $display("FAIL wrap_data%0d: got %h want %h", i, beats[i], 64'hF0 + 64'(i)); end
    end
  endtask

  task automatic test_async_reset();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 6; i++) push(64'h60 + 64'(i));
    clear_mon();
    repeat (3) tick();
    n_cmp++; if (bus.m_valid !== 1'b1) begin n_bad++; $display("FAIL areset_pre_valid: got %b want 1", bus.m_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.m_valid !== 1'b0) begin n_bad++; $display("FAIL areset_valid: got %b want 0", bus.m_valid); end
    n_cmp++; if (bus.m_count !== 2'd0) begin n_bad++; $display("FAIL areset_count: got %0d want 0", bus.m_count); end
    n_cmp++; if (bus.m_data !== 64'h0) begin n_bad++; $display("FAIL areset_data: got %h want 0", bus.m_data); end
    n_cmp++; if (bus.fifo_rden !== 1'b0) begin n_bad++; $display("FAIL areset_rden: got %b want 0", bus.fifo_rden); end
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    rst_n = 1'b1;
    push(64'h70);
    push(64'h71);
    clear_mon();
    repeat (6) tick();
    n_cmp++; if (beats.size() !== 2) begin n_bad++; $display("FAIL areset_beats: got %0d want 2", beats.size()); end
    for (int i = 0; i < beats.size() && i < 2; i++) begin
      n_cmp++; if (beats[i] !== 64'h70 + 64'(i)) begin n_bad++; $display("FAIL areset_data%0d: got %h want %h", i, beats[i], 64'h70 + 64'(i)); end
    end
  endtask

  initial begin
    bus.m_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
